// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller and its datapath.
// Contents: FSM state enumeration, ResultSrc encodings, ALUControl and
// FPUControl code constants, the multiply MulOp pattern, and the packed
// control word that the FSM registers and drives onto its output ports.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI,
    MULEX, ALUWB, BRANCH, FPUEX, FPUWB
  } state_t;

  // ResultSrc encodings
  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC  = 2'b10;
  localparam logic [1:0] RS_FPU = 2'b11;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_MUL   = 3'b100;
  localparam logic [2:0] ALU_UMULL = 3'b101;
  localparam logic [2:0] ALU_SMULL = 3'b110;

  // FPUControl codes (taken straight from Funct[2:1])
  localparam logic [1:0] FPU_ADD = 2'b00;
  localparam logic [1:0] FPU_SUB = 2'b01;
  localparam logic [1:0] FPU_MUL = 2'b10;
  localparam logic [1:0] FPU_DIV = 2'b11;

  // Instruction bits [7:4] that mark a multiply
  localparam logic [3:0] MULOP_MUL = 4'b1001;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       mul_write;
    logic       fpu_start;
    logic       fpu_timeout;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [2:0] alu_control;
    logic [1:0] flag_w;
    logic [1:0] fpu_control;
    logic [1:0] fpu_flag_w;
  } ctrl_t;

  // Control word of the FETCH state, loaded by reset.
  localparam ctrl_t CTRL_FETCH = '{ir_write: 1'b1, next_pc: 1'b1, alu_src_a: 1'b1,
                                   alu_src_b: 2'b10, result_src: RS_PC, default: '0};

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: combinational Funct/MulOp table.
// Ports:
//   funct      in  6  instruction bits [25:20]
//   mul_op     in  4  instruction bits [7:4]
//   is_mul     out 1  data-processing encoding is a multiply
//   dp_alu     out 3  ALUControl for data-processing (EXECR/EXECI)
//   dp_flag_w  out 2  FlagW for data-processing
//   mul_alu    out 3  ALUControl for multiplies (MULEX)
//   mul_flag_w out 2  FlagW for the final MULEX cycle
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [3:0] mul_op,
  output logic       is_mul,
  output logic [2:0] dp_alu,
  output logic [1:0] dp_flag_w,
  output logic [2:0] mul_alu,
  output logic [1:0] mul_flag_w
);

  always_comb begin
    case (funct[4:1])
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      default: dp_alu = ALU_ADD;
    endcase
    // C/V flags only make sense for add/subtract.
    dp_flag_w = {funct[0], funct[0] & ((dp_alu == ALU_ADD) | (dp_alu == ALU_SUB))};

    case (funct[3:1])
      3'b000:  mul_alu = ALU_MUL;
      3'b100:  mul_alu = ALU_UMULL;
      3'b110:  mul_alu = ALU_SMULL;
      default: mul_alu = ALU_MUL;
    endcase
    mul_flag_w = {funct[0], 1'b0};

    is_mul = ~funct[5] & (mul_op == MULOP_MUL);
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for a multicycle ARM-style core
// with a multi-cycle multiplier and an FPU handshake.
// Ports:
//   clk, reset (sync, active-high), Op[1:0], Funct[5:0], Rd[3:0], MulOp[3:0],
//   FPUDone (single-cycle pulse)
//   Outputs: IRWrite, AdrSrc, ALUSrcA, NextPC, Branch, RegW, MemW, MulWrite,
//   FPUStart, FPUTimeout, ALUSrcB[1:0], ResultSrc[1:0], ImmSrc[1:0],
//   RegSrc[1:0], ALUControl[2:0], FlagW[1:0], FPUControl[1:0], FPUFlagW[1:0],
//   state_dbg[3:0] (current FSM state, for observation only)
// FPU handshake: FPUStart is high only in the first FPUEX cycle; the FSM waits
// in FPUEX until FPUDone is sampled high on a rising edge. FPUTimeout is high
// in the FPU_TIMEOUT-th FPUEX cycle; if FPUDone is sampled at the end of that
// same cycle, FPUWB still wins, otherwise the FSM returns to FETCH.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MUL_CYCLES  = 3,
  parameter int FPU_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] MulOp,
  input  logic       FPUDone,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic       NextPC,
  output logic       Branch,
  output logic       RegW,
  output logic       MemW,
  output logic       MulWrite,
  output logic       FPUStart,
  output logic       FPUTimeout,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] FlagW,
  output logic [1:0] FPUControl,
  output logic [1:0] FPUFlagW,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);
  localparam logic [7:0] FPU_LIMIT = 8'(FPU_TIMEOUT);

  state_t     state, nxt;
  logic [3:0] mul_cnt, mul_nxt;   // MULEX cycles left after the current one
  logic [7:0] fpu_cnt, fpu_nxt;   // 1-based index of the current FPUEX cycle
  logic       from_mul, from_mul_nxt;
  ctrl_t      ctrl_q, ctrl_d, ctrl_o;

  logic       is_mul;
  logic [2:0] dp_alu, mul_alu;
  logic [1:0] dp_flag_w, mul_flag_w;

  alu_decoder u_alu_decoder (
    .funct      (Funct),
    .mul_op     (MulOp),
    .is_mul     (is_mul),
    .dp_alu     (dp_alu),
    .dp_flag_w  (dp_flag_w),
    .mul_alu    (mul_alu),
    .mul_flag_w (mul_flag_w)
  );

  // Next state and counters, then the control word of that next state, so
  // the outputs are registered together with the state they belong to.
  always_comb begin
    nxt          = state;
    mul_nxt      = mul_cnt;
    fpu_nxt      = fpu_cnt;
    from_mul_nxt = from_mul;
    case (state)
      FETCH: nxt = DECODE;
      DECODE: begin
        from_mul_nxt = 1'b0;
        case (Op)
          2'b00: begin
            if (is_mul) begin
              nxt          = MULEX;
              mul_nxt      = MUL_LOAD;
              from_mul_nxt = 1'b1;
            end else if (Funct[5]) begin
              nxt = EXECI;
            end else begin
              nxt = EXECR;
            end
          end
          2'b01: nxt = MEMADR;
          2'b10: nxt = BRANCH;
          default: begin
            nxt     = FPUEX;
            fpu_nxt = 8'd1;
          end
        endcase
      end
      MEMADR:       nxt = Funct[0] ? MEMRD : MEMWR;
      MEMRD:        nxt = MEMWB;
      EXECR, EXECI: nxt = ALUWB;
      MULEX: begin
        if (mul_cnt == 4'd0) nxt = ALUWB;
        else                 mul_nxt = mul_cnt - 4'd1;
      end
      FPUEX: begin
        if (FPUDone)                   nxt = FPUWB;
        else if (fpu_cnt == FPU_LIMIT) nxt = FETCH;
        else                           fpu_nxt = fpu_cnt + 8'd1;
      end
      ALUWB: begin
        nxt          = FETCH;
        from_mul_nxt = 1'b0;
      end
      default: nxt = FETCH;
    endcase

    ctrl_d = '0;
    case (nxt)
      FETCH: ctrl_d = CTRL_FETCH;
      DECODE: begin
        ctrl_d.alu_src_a  = 1'b1;
        ctrl_d.alu_src_b  = 2'b10;
        ctrl_d.result_src = RS_PC;
      end
      MEMADR: begin
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.imm_src   = 2'b01;
        ctrl_d.reg_src   = 2'b10;
      end
      MEMRD: ctrl_d.adr_src = 1'b1;
      MEMWB: begin
        ctrl_d.reg_w      = 1'b1;
        ctrl_d.result_src = RS_MEM;
      end
      MEMWR: begin
        ctrl_d.adr_src = 1'b1;
        ctrl_d.mem_w   = 1'b1;
        ctrl_d.reg_src = 2'b10;
      end
      EXECR, EXECI: begin
        ctrl_d.alu_src_b   = (nxt == EXECI) ? 2'b01 : 2'b00;
        ctrl_d.alu_control = dp_alu;
        ctrl_d.flag_w      = dp_flag_w;
      end
      MULEX: begin
        ctrl_d.alu_control = mul_alu;
        if (mul_nxt == 4'd0) ctrl_d.flag_w = mul_flag_w;
      end
      ALUWB: begin
        ctrl_d.reg_w      = 1'b1;
        ctrl_d.result_src = RS_ALU;
        ctrl_d.mul_write  = from_mul_nxt;
        // A write to R15 from a normal ALU op is a jump.
        ctrl_d.next_pc    = ~from_mul_nxt & (Rd == 4'hF);
      end
      BRANCH: begin
        ctrl_d.branch     = 1'b1;
        ctrl_d.alu_src_b  = 2'b01;
        ctrl_d.result_src = RS_PC;
        ctrl_d.imm_src    = 2'b10;
        ctrl_d.reg_src    = 2'b01;
      end
      FPUEX: begin
        ctrl_d.fpu_start   = (fpu_nxt == 8'd1);
        ctrl_d.fpu_timeout = (fpu_nxt == FPU_LIMIT);
        ctrl_d.fpu_control = Funct[2:1];
      end
      FPUWB: begin
        ctrl_d.reg_w      = 1'b1;
        ctrl_d.result_src = RS_FPU;
        ctrl_d.fpu_flag_w = {Funct[0], 1'b0};
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      mul_cnt  <= 4'd0;
      fpu_cnt  <= 8'd0;
      from_mul <= 1'b0;
      ctrl_q   <= CTRL_FETCH;
    end else begin
      state    <= nxt;
      mul_cnt  <= mul_nxt;
      fpu_cnt  <= fpu_nxt;
      from_mul <= from_mul_nxt;
      ctrl_q   <= ctrl_d;
    end
  end

  // Outputs are forced low for as long as reset is held; the register already
  // holds the FETCH word, so the first cycle after release drives FETCH.
  assign ctrl_o = reset ? '0 : ctrl_q;

  assign IRWrite    = ctrl_o.ir_write;
  assign AdrSrc     = ctrl_o.adr_src;
  assign ALUSrcA    = ctrl_o.alu_src_a;
  assign NextPC     = ctrl_o.next_pc;
  assign Branch     = ctrl_o.branch;
  assign RegW       = ctrl_o.reg_w;
  assign MemW       = ctrl_o.mem_w;
  assign MulWrite   = ctrl_o.mul_write;
  assign FPUStart   = ctrl_o.fpu_start;
  assign FPUTimeout = ctrl_o.fpu_timeout;
  assign ALUSrcB    = ctrl_o.alu_src_b;
  assign ResultSrc  = ctrl_o.result_src;
  assign ImmSrc     = ctrl_o.imm_src;
  assign RegSrc     = ctrl_o.reg_src;
  assign ALUControl = ctrl_o.alu_control;
  assign FlagW      = ctrl_o.flag_w;
  assign FPUControl = ctrl_o.fpu_control;
  assign FPUFlagW   = ctrl_o.fpu_flag_w;
  assign state_dbg  = state;

endmodule
